// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-Lite read arbiter.
//   t_arb_state   : arbiter FSM state encoding
//   AXI_RESP_*    : R_RESP encodings
//   AXI_PROT_*    : AR_PROT values for instruction / data fetches
//   port_onehot() : requester index to one-hot grant vector
package axi4_lite_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ADDR  = 3'd2,
    DATA  = 3'd3,
    DONE  = 3'd4
  } t_arb_state;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT_INSTR = 3'b100;
  localparam logic [2:0] AXI_PROT_DATA  = 3'b000;

  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter, purely combinational.
//   req_i        : request vector, bit 0 = port 0
//   last_grant_i : index of the port served most recently (held by the parent)
//   grant_o      : one-hot winner, 0 when nothing is requested
module rr_arbiter_2
  import axi4_lite_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      // On a tie the port that was not served last wins.
      2'b11:   grant_o = port_onehot(~last_grant_i);
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/axi4_lite_read_arbiter.sv
// Shares one AXI4-Lite read channel between the I-cache (port 0) and the D-cache (port 1).
// Ports:
//   clk_i, arst_i            : clock, asynchronous active-high reset
//   req_i, req_addr_i        : per-requester level request and address (sampled at grant)
//   grant_o                  : one-hot owner while a transaction is in flight
//   resp_valid_o/data/err    : one-cycle response pulse to the owner
//   start_read_o             : one-cycle pulse arming the read slave ahead of AR_VALID
//   AR_* / R_*               : AXI4-Lite read address and read data channels (master side)
// Every output is either a flop or a decode of the FSM state, so nothing on the inputs
// reaches an output combinationally. A slave that never answers holds the FSM forever.
module axi4_lite_read_arbiter
  import axi4_lite_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 32
) (
  input  logic                           clk_i,
  input  logic                           arst_i,
  input  logic [1:0]                     req_i,
  input  logic [1:0][AXI_ADDR_WIDTH-1:0] req_addr_i,
  output logic [1:0]                     grant_o,
  output logic [1:0]                     resp_valid_o,
  output logic [AXI_DATA_WIDTH-1:0]      resp_data_o,
  output logic                           resp_err_o,
  output logic                           start_read_o,
  output logic                           AR_VALID,
  output logic [AXI_ADDR_WIDTH-1:0]      AR_ADDR,
  output logic [2:0]                     AR_PROT,
  input  logic                           AR_READY,
  input  logic                           R_VALID,
  input  logic [AXI_DATA_WIDTH-1:0]      R_DATA,
  input  logic [1:0]                     R_RESP,
  output logic                           R_READY
);

  t_arb_state                state_q, state_d;
  logic                      owner_q, owner_d;
  logic                      last_grant_q, last_grant_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]                prot_q, prot_d;
  logic [AXI_DATA_WIDTH-1:0] data_q, data_d;
  logic                      err_q, err_d;

  logic [1:0] arb_grant;

  rr_arbiter_2 u_rr_arbiter_2 (
    .req_i        (req_i),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    prot_d       = prot_q;
    data_d       = data_q;
    err_d        = err_q;

    case (state_q)
      IDLE: begin
        if (|req_i) begin
          owner_d = arb_grant[1];
          addr_d  = req_addr_i[arb_grant[1]];
          prot_d  = arb_grant[1] ? AXI_PROT_DATA : AXI_PROT_INSTR;
          state_d = START;
        end
      end
      START: state_d = ADDR;
      ADDR: begin
        if (AR_READY) state_d = DATA;
      end
      DATA: begin
        if (R_VALID) begin
          data_d  = R_DATA;
          // Error is R_RESP[1]: SLVERR and DECERR both flag, OKAY/EXOKAY do not.
          err_d   = (R_RESP == AXI_RESP_SLVERR) || (R_RESP == AXI_RESP_DECERR);
          state_d = DONE;
        end
      end
      DONE: begin
        last_grant_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;  // port 0 wins the first tie
      addr_q       <= '0;
      prot_q       <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      prot_q       <= prot_d;
      data_q       <= data_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    grant_o      = (state_q != IDLE) ? port_onehot(owner_q) : 2'b00;
    resp_valid_o = (state_q == DONE) ? port_onehot(owner_q) : 2'b00;
    resp_data_o  = data_q;
    resp_err_o   = err_q;
    start_read_o = (state_q == START);
    AR_VALID     = (state_q == ADDR);
    AR_ADDR      = addr_q;
    AR_PROT      = prot_q;
    R_READY      = (state_q == DATA);
  end

endmodule

// File: tb/tb_axi4_lite_read_arbiter.sv
// Self-checking bench for axi4_lite_read_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_axi4_lite_read_arbiter;

  localparam int AW = 64;
  localparam int DW = 32;

  logic               clk_i = 1'b0;
  logic               arst_i = 1'b1;
  logic [1:0]         req_i = '0;
  logic [1:0][AW-1:0] req_addr_i = '0;
  logic [1:0]         grant_o;
  logic [1:0]         resp_valid_o;
  logic [DW-1:0]      resp_data_o;
  logic               resp_err_o;
  logic               start_read_o;
  logic               AR_VALID;
  logic [AW-1:0]      AR_ADDR;
  logic [2:0]         AR_PROT;
  logic               AR_READY = 1'b0;
  logic               R_VALID = 1'b0;
  logic [DW-1:0]      R_DATA = '0;
  logic [1:0]         R_RESP = '0;
  logic               R_READY;

  axi4_lite_read_arbiter #(
    .AXI_ADDR_WIDTH (AW),
    .AXI_DATA_WIDTH (DW)
  ) dut (
    .clk_i        (clk_i),
    .arst_i       (arst_i),
    .req_i        (req_i),
    .req_addr_i   (req_addr_i),
    .grant_o      (grant_o),
    .resp_valid_o (resp_valid_o),
    .resp_data_o  (resp_data_o),
    .resp_err_o   (resp_err_o),
    .start_read_o (start_read_o),
    .AR_VALID     (AR_VALID),
    .AR_ADDR      (AR_ADDR),
    .AR_PROT      (AR_PROT),
    .AR_READY     (AR_READY),
    .R_VALID      (R_VALID),
    .R_DATA       (R_DATA),
    .R_RESP       (R_RESP),
    .R_READY      (R_READY)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Slave behaviour knobs; a negative delay means random 0..3 per transaction.
  int            ar_delay_cfg = 0;
  int            r_delay_cfg  = 0;
  bit            noise_en     = 1'b0;
  bit            rand_data    = 1'b0;
  logic [DW-1:0] rdata_cfg    = '0;
  logic [1:0]    rresp_cfg    = '0;
  int            ar_cnt = 0, r_cnt = 0, ar_wait = 0, r_wait = 0;
  logic [AW+2:0] ar_log[$];
  logic [DW+1:0] r_log[$];

  // Memory-side slave, driven on the falling edge. Outside its windows it may toggle
  // AR_READY / R_VALID / R_DATA randomly; the arbiter must ignore that.
  always @(negedge clk_i) begin
    if (arst_i) begin
      AR_READY = 1'b0;
      R_VALID  = 1'b0;
      ar_cnt   = 0;
      r_cnt    = 0;
    end else begin
      if (AR_VALID) begin
        if (ar_cnt == 0) ar_wait = (ar_delay_cfg < 0) ? int'($urandom_range(0, 3)) : ar_delay_cfg;
        AR_READY = (ar_cnt >= ar_wait);
        if (AR_READY) ar_log.push_back({AR_ADDR, AR_PROT});
        ar_cnt++;
      end else begin
        ar_cnt   = 0;
        AR_READY = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (R_READY) begin
        if (r_cnt == 0) r_wait = (r_delay_cfg < 0) ? int'($urandom_range(0, 3)) : r_delay_cfg;
        R_VALID = (r_cnt >= r_wait);
        if (R_VALID) begin
          R_DATA = rand_data ? DW'($urandom) : rdata_cfg;
          R_RESP = rand_data ? 2'($urandom_range(0, 3)) : rresp_cfg;
          r_log.push_back({R_DATA, R_RESP});
        end
        r_cnt++;
      end else begin
        r_cnt   = 0;
        R_VALID = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noise_en) begin
          R_DATA = DW'($urandom);
          R_RESP = 2'($urandom_range(0, 3));
        end
      end
    end
  end

  function automatic logic [1:0] oh(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic reset_dut();
    arst_i       = 1'b1;
    req_i        = '0;
    ar_delay_cfg = 0;
    r_delay_cfg  = 0;
    noise_en     = 1'b0;
    rand_data    = 1'b0;
    tick();
    tick();
    arst_i = 1'b0;
    ar_log.delete();
    r_log.delete();
  endtask

  // Stimulus only: raise one request, wait for its pulse, drop it, spend the idle cycle.
  task automatic serve(input logic port, input logic [AW-1:0] addr, output logic [1:0] got_rv,
                       output logic [DW-1:0] got_data, output logic got_err, output int lat);
    req_i[port]      = 1'b1;
    req_addr_i[port] = addr;
    got_rv = '0; got_data = '0; got_err = 1'b0; lat = -1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (resp_valid_o != 2'b00) begin
        got_rv = resp_valid_o; got_data = resp_data_o; got_err = resp_err_o; lat = k;
        break;
      end
    end
    req_i[port] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    arst_i = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({grant_o, resp_valid_o, start_read_o, AR_VALID, R_READY, resp_err_o} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000000",
               {grant_o, resp_valid_o, start_read_o, AR_VALID, R_READY, resp_err_o});
    end
    n_checks++;
    if (AR_ADDR !== '0 || AR_PROT !== 3'b000 || resp_data_o !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got addr %h prot %b data %h expected all 0",
               AR_ADDR, AR_PROT, resp_data_o);
    end
    arst_i = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (grant_o !== 2'b00 || start_read_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got grant %b start %b expected 00 0", grant_o, start_read_o);
    end
  endtask

  // Port 1 alone, zero-wait slave: cycle-exact timing of every control output.
  task automatic test_single_port1();
    logic [6:0] obs, exp_v;
    rdata_cfg = 32'hDEAD_BEEF;
    rresp_cfg = 2'b00;
    req_i[1]      = 1'b1;
    req_addr_i[1] = 64'h80;
    for (int k = 1; k <= 6; k++) begin
      tick();
      obs = {grant_o, resp_valid_o, start_read_o, AR_VALID, R_READY};
      case (k)
        1:       exp_v = 7'b10_00_1_0_0;
        2:       exp_v = 7'b10_00_0_1_0;
        3:       exp_v = 7'b10_00_0_0_1;
        4:       exp_v = 7'b10_10_0_0_0;
        default: exp_v = 7'b00_00_0_0_0;
      endcase
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL single_c%0d: got {grant,rv,start,arv,rrdy}=%b expected %b", k, obs, exp_v);
      end
      if (k == 2) begin
        n_checks++;
        if (AR_ADDR !== 64'h80 || AR_PROT !== 3'b000) begin
          n_fail++;
          $display("FAIL single_ar: got addr %h prot %b expected 80 000", AR_ADDR, AR_PROT);
        end
      end
      if (k == 4) begin
        n_checks++;
        if (resp_data_o !== 32'hDEAD_BEEF || resp_err_o !== 1'b0) begin
          n_fail++;
          $display("FAIL single_resp: got data %h err %b expected deadbeef 0",
                   resp_data_o, resp_err_o);
        end
        req_i[1] = 1'b0;
      end
    end
  endtask

  // Both ports held: grants alternate 0,1,0,1 with 5-cycle spacing.
  task automatic test_tie_alternate();
    logic [1:0]    rv_q[$];
    logic [AW+2:0] ar_q[$];
    int            st_q[$];
    logic          prev_av = 1'b0;
    logic [AW-1:0] exp_addr;
    logic [2:0]    exp_prot;
    reset_dut();
    req_addr_i[0] = 64'h100;
    req_addr_i[1] = 64'h200;
    req_i = 2'b11;
    for (int k = 1; k <= 40 && rv_q.size() < 4; k++) begin
      tick();
      if (start_read_o) st_q.push_back(k);
      if (AR_VALID && !prev_av) ar_q.push_back({AR_ADDR, AR_PROT});
      prev_av = AR_VALID;
      if (resp_valid_o != 2'b00) begin
        rv_q.push_back(resp_valid_o);
        if (rv_q.size() == 4) req_i = 2'b00;
      end
    end
    req_i = 2'b00;
    n_checks++;
    if (rv_q.size() != 4 || ar_q.size() != 4 || st_q.size() != 4) begin
      n_fail++;
      $display("FAIL tie_count: got %0d responses expected 4", rv_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp_addr = (i % 2 == 0) ? 64'h100 : 64'h200;
        exp_prot = (i % 2 == 0) ? 3'b100 : 3'b000;
        n_checks++;
        if (rv_q[i] !== oh(1'(i % 2)) || ar_q[i] !== {exp_addr, exp_prot}) begin
          n_fail++;
          $display("FAIL tie_order_%0d: got rv %b ar %h expected rv %b ar %h", i, rv_q[i],
                   ar_q[i], oh(1'(i % 2)), {exp_addr, exp_prot});
        end
      end
      n_checks++;
      if (st_q[0] != 1 || st_q[1] - st_q[0] != 5 || st_q[3] - st_q[2] != 5) begin
        n_fail++;
        $display("FAIL tie_spacing: got starts %0d %0d %0d %0d expected 1 6 11 16",
                 st_q[0], st_q[1], st_q[2], st_q[3]);
      end
    end
    tick();
    tick();
  endtask

  // Slow slave: AR_ADDR stable across the wait, R_READY only in the data phase.
  task automatic test_slow_slave();
    int av_cnt = 0, rr_cnt = 0, rv_cnt = 0, bad = 0;
    logic [DW-1:0] got_data = '0;
    ar_delay_cfg = 3;
    r_delay_cfg  = 4;
    rdata_cfg    = 32'hA5A5_0001;
    rresp_cfg    = 2'b00;
    req_addr_i[0] = 64'h3000;
    req_i[0]      = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (AR_VALID) begin
        av_cnt++;
        n_checks++;
        if (AR_ADDR !== 64'h3000 || AR_PROT !== 3'b100) begin
          n_fail++;
          $display("FAIL slow_ar_stable: got addr %h prot %b expected 3000 100", AR_ADDR, AR_PROT);
        end
      end
      if (R_READY) begin
        rr_cnt++;
        if (AR_VALID || start_read_o || resp_valid_o != 2'b00 || grant_o != 2'b01) bad++;
      end
      if (resp_valid_o != 2'b00) begin
        rv_cnt++;
        got_data = resp_data_o;
        req_i[0] = 1'b0;
      end
    end
    n_checks++;
    if (av_cnt != 4 || rr_cnt != 5 || rv_cnt != 1 || bad != 0) begin
      n_fail++;
      $display("FAIL slow_counts: got arv %0d rrdy %0d rv %0d bad %0d expected 4 5 1 0",
               av_cnt, rr_cnt, rv_cnt, bad);
    end
    n_checks++;
    if (got_data !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL slow_data: got %h expected a5a50001", got_data);
    end
    ar_delay_cfg = 0;
    r_delay_cfg  = 0;
  endtask

  // SLVERR forwards data with err=1; the following OKAY clears err.
  task automatic test_error_resp();
    logic [1:0]    rv;
    logic [DW-1:0] d;
    logic          e;
    int            lat;
    rdata_cfg = 32'h1234_5678;
    rresp_cfg = 2'b10;
    serve(1'b1, 64'h500, rv, d, e, lat);
    n_checks++;
    if (rv !== 2'b10 || d !== 32'h1234_5678 || e !== 1'b1) begin
      n_fail++;
      $display("FAIL err_slverr: got rv %b data %h err %b expected 10 12345678 1", rv, d, e);
    end
    rdata_cfg = 32'hCAFE_F00D;
    rresp_cfg = 2'b00;
    serve(1'b0, 64'h600, rv, d, e, lat);
    n_checks++;
    if (rv !== 2'b01 || d !== 32'hCAFE_F00D || e !== 1'b0 || lat != 4) begin
      n_fail++;
      $display("FAIL err_okay: got rv %b data %h err %b lat %0d expected 01 cafef00d 0 4",
               rv, d, e, lat);
    end
  endtask

  // Port 0 was served last, so without reset port 1 would win the next tie.
  task automatic test_reset_mid();
    bit in_data = 1'b0;
    r_delay_cfg   = 20;
    req_addr_i[1] = 64'h700;
    req_i = 2'b10;
    for (int k = 0; k < 10 && !in_data; k++) begin
      tick();
      in_data = R_READY;
    end
    n_checks++;
    if (!in_data) begin
      n_fail++;
      $display("FAIL rstmid_reach_data: got R_READY 0 expected 1 within 10 cycles");
    end
    #2 arst_i = 1'b1;
    #1;
    n_checks++;
    if ({grant_o, resp_valid_o, start_read_o, AR_VALID, R_READY, resp_err_o} !== 8'h00 ||
        AR_ADDR !== '0 || resp_data_o !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got ctrl %b addr %h data %h expected all 0",
               {grant_o, resp_valid_o, start_read_o, AR_VALID, R_READY, resp_err_o},
               AR_ADDR, resp_data_o);
    end
    req_i = 2'b00;
    r_delay_cfg = 0;
    tick();
    n_checks++;
    if (resp_valid_o !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_no_pulse: got %b expected 00", resp_valid_o);
    end
    arst_i = 1'b0;
    ar_log.delete();
    r_log.delete();
    req_addr_i[0] = 64'h800;
    req_addr_i[1] = 64'h900;
    req_i = 2'b11;
    tick();
    n_checks++;
    if (start_read_o !== 1'b1 || grant_o !== 2'b01) begin
      n_fail++;
      $display("FAIL rstmid_tie: got start %b grant %b expected 1 01", start_read_o, grant_o);
    end
    for (int k = 0; k < 30 && req_i != 2'b00; k++) begin
      tick();
      if (resp_valid_o[0]) req_i[0] = 1'b0;
      if (resp_valid_o[1]) req_i[1] = 1'b0;
    end
    req_i = 2'b00;
    tick();
  endtask

  // Requester withdraws and changes its address mid-flight; transaction is unaffected.
  task automatic test_drop_req();
    int         av_cnt = 0;
    logic [1:0] got_rv = '0;
    ar_delay_cfg  = 2;
    rdata_cfg     = 32'h0BAD_CAFE;
    req_addr_i[0] = 64'h4000;
    req_i[0]      = 1'b1;
    for (int k = 0; k < 30 && got_rv == 2'b00; k++) begin
      tick();
      if (AR_VALID) begin
        av_cnt++;
        req_i[0]      = 1'b0;
        req_addr_i[0] = 64'hFFFF_0000;
        n_checks++;
        if (AR_ADDR !== 64'h4000) begin
          n_fail++;
          $display("FAIL drop_addr: got %h expected 4000", AR_ADDR);
        end
      end
      if (resp_valid_o != 2'b00) got_rv = resp_valid_o;
    end
    n_checks++;
    if (got_rv !== 2'b01 || av_cnt != 3 || resp_data_o !== 32'h0BAD_CAFE) begin
      n_fail++;
      $display("FAIL drop_pulse: got rv %b arv cycles %0d data %h expected 01 3 0badcafe",
               got_rv, av_cnt, resp_data_o);
    end
    ar_delay_cfg = 0;
    tick();
  endtask

  // Random requesters, random slave delays/data and bus noise vs. a transaction model.
  task automatic test_random();
    int            decisions = 0, responses = 0, exp_start_cyc = -1;
    bit            bus_free = 1'b1, pending_free = 1'b0;
    logic          last = 1'b1, exp_owner = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [2:0]    exp_prot = '0;
    logic [AW+2:0] ar_e;
    logic [DW+1:0] r_e;
    reset_dut();
    ar_delay_cfg = -1;
    r_delay_cfg  = -1;
    noise_en     = 1'b1;
    rand_data    = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      tick();
      if (pending_free) begin
        bus_free = 1'b1;
        pending_free = 1'b0;
      end
      if (start_read_o) begin
        n_checks++;
        if (cyc != exp_start_cyc || grant_o !== oh(exp_owner)) begin
          n_fail++;
          $display("FAIL rand_start: got cyc %0d grant %b expected cyc %0d grant %b",
                   cyc, grant_o, exp_start_cyc, oh(exp_owner));
        end
      end
      if (bus_free) begin
        n_checks++;
        if (grant_o !== 2'b00) begin
          n_fail++;
          $display("FAIL rand_idle_grant: got %b expected 00 at cyc %0d", grant_o, cyc);
        end
      end
      if (resp_valid_o != 2'b00) begin
        responses++;
        n_checks++;
        if (resp_valid_o !== oh(exp_owner) || ar_log.size() == 0 || r_log.size() == 0) begin
          n_fail++;
          $display("FAIL rand_resp_port: got %b expected %b (ar log %0d r log %0d)",
                   resp_valid_o, oh(exp_owner), ar_log.size(), r_log.size());
        end else begin
          ar_e = ar_log.pop_front();
          r_e  = r_log.pop_front();
          n_checks++;
          if (ar_e !== {exp_addr, exp_prot} || resp_data_o !== r_e[DW+1:2] ||
              resp_err_o !== r_e[1]) begin
            n_fail++;
            $display("FAIL rand_resp_data: got ar %h data %h err %b expected ar %h data %h err %b",
                     ar_e, resp_data_o, resp_err_o, {exp_addr, exp_prot}, r_e[DW+1:2], r_e[1]);
          end
        end
        last = exp_owner;
        pending_free = 1'b1;
        req_i[exp_owner] = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        if (i < 1300 && !req_i[p] && $urandom_range(0, 3) == 0) req_i[p] = 1'b1;
        if ($urandom_range(0, 3) == 0) req_addr_i[p] = {$urandom, $urandom};
      end
      if (bus_free && req_i != 2'b00) begin
        exp_owner     = (req_i == 2'b11) ? ~last : req_i[1];
        exp_addr      = req_addr_i[exp_owner];
        exp_prot      = exp_owner ? 3'b000 : 3'b100;
        exp_start_cyc = cyc + 1;
        bus_free      = 1'b0;
        decisions++;
      end
      if (i >= 1300 && bus_free && req_i == 2'b00) break;
    end
    n_checks++;
    if (!bus_free || decisions != responses || decisions < 20) begin
      n_fail++;
      $display("FAIL rand_drain: got idle %b grants %0d responses %0d expected idle 1, equal, >=20",
               bus_free, decisions, responses);
    end
    noise_en  = 1'b0;
    rand_data = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_port1();
    test_tie_alternate();
    test_slow_slave();
    test_error_resp();
    test_reset_mid();
    test_drop_req();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
